// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between two requesters, with clear sequencing.
// Optional grant locking is enabled by defining STACK_ARB_LOCK_EN.
module stack_arbiter #(
  parameter int DATA_W     = 2,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  op0,
  input  logic                  op1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_W-1:0]     rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic                  stk_init,
  output logic [DATA_W-1:0]     stk_data_in,
  input  logic [DATA_W-1:0]     stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty
);

  typedef enum logic {ST_ARB, ST_CLR} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_prio;
  logic                w_prioNext;
  logic                w_prioEff;
  logic [1:0]          r_rvalid;
  logic [1:0]          r_err;
  logic [1:0]          w_rvalidNext;
  logic [1:0]          w_errNext;
  logic [DEPTH_LOG2:0] r_level;
  logic [DEPTH_LOG2:0] w_levelNext;
  logic [1:0]          w_elig;
  logic [1:0]          w_gnt;
  logic                w_sel;
  logic                w_op;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_push;
  logic                w_pop;
  logic                w_init;
  logic                w_busy;
  logic [DATA_W-1:0]   w_dataIn;

`ifdef STACK_ARB_LOCK_EN
  logic r_lockValid;
  logic r_lockOwner;
  logic w_lockValidNext;
  logic w_lockOwnerNext;
  logic w_ownerLock;

  assign w_ownerLock = r_lockOwner ? lock1 : lock0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lockValid <= 1'b0;
      r_lockOwner <= 1'b0;
    end else begin
      r_lockValid <= w_lockValidNext;
      r_lockOwner <= w_lockOwnerNext;
    end
  end
`else
  logic w_unusedLock;
  assign w_unusedLock = lock0 | lock1;
`endif

  // Responses are computed in the grant cycle and presented one cycle later.
  always_comb begin
    w_nextState  = r_state;
    w_prioEff    = r_prio;
    w_elig       = {req1, req0};
    w_gnt        = 2'b00;
    w_sel        = 1'b0;
    w_op         = 1'b0;
    w_wdata      = '0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_init       = 1'b0;
    w_busy       = 1'b0;
    w_dataIn     = '0;
    w_rvalidNext = 2'b00;
    w_errNext    = 2'b00;
    w_levelNext  = r_level;
`ifdef STACK_ARB_LOCK_EN
    w_lockValidNext = r_lockValid;
    w_lockOwnerNext = r_lockOwner;
    if (r_lockValid) begin
      if (w_ownerLock) begin
        w_elig = r_lockOwner ? {req1, 1'b0} : {1'b0, req0};
      end else begin
        w_prioEff       = ~r_lockOwner;
        w_lockValidNext = 1'b0;
      end
    end
`endif
    w_prioNext = w_prioEff;
    if (!rst) begin
      case (r_state)
        ST_ARB: begin
          if (clr) begin
            w_nextState = ST_CLR;
            w_levelNext = '0;
`ifdef STACK_ARB_LOCK_EN
            w_lockValidNext = 1'b0;
`endif
          end else begin
            if (w_elig == 2'b11) w_gnt = w_prioEff ? 2'b10 : 2'b01;
            else                 w_gnt = w_elig;
            if (w_gnt != 2'b00) begin
              w_sel      = w_gnt[1];
              w_op       = w_sel ? op1 : op0;
              w_wdata    = w_sel ? wdata1 : wdata0;
              w_prioNext = ~w_sel;
`ifdef STACK_ARB_LOCK_EN
              if (w_sel ? lock1 : lock0) begin
                w_prioNext      = w_prioEff;
                w_lockValidNext = 1'b1;
                w_lockOwnerNext = w_sel;
              end
`endif
              // Illegal requests still consume the grant but never touch the stack.
              if (w_op) begin
                if (!stk_empty) begin
                  w_pop               = 1'b1;
                  w_levelNext         = r_level - 1'b1;
                  w_rvalidNext[w_sel] = 1'b1;
                end else begin
                  w_errNext[w_sel] = 1'b1;
                end
              end else begin
                if (!stk_full) begin
                  w_push      = 1'b1;
                  w_dataIn    = w_wdata;
                  w_levelNext = r_level + 1'b1;
                end else begin
                  w_errNext[w_sel] = 1'b1;
                end
              end
            end
          end
        end
        ST_CLR: begin
          w_init      = 1'b1;
          w_busy      = 1'b1;
          w_levelNext = '0;
          w_nextState = ST_ARB;
        end
        default: w_nextState = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_ARB;
      r_prio   <= 1'b0;
      r_level  <= '0;
      r_rvalid <= 2'b00;
      r_err    <= 2'b00;
    end else begin
      r_state  <= w_nextState;
      r_prio   <= w_prioNext;
      r_level  <= w_levelNext;
      r_rvalid <= w_rvalidNext;
      r_err    <= w_errNext;
    end
  end

  assign gnt0        = w_gnt[0];
  assign gnt1        = w_gnt[1];
  assign rvalid0     = r_rvalid[0];
  assign rvalid1     = r_rvalid[1];
  assign err0        = r_err[0];
  assign err1        = r_err[1];
  assign rdata       = stk_data_out;
  assign level       = r_level;
  assign busy        = w_busy;
  assign stk_push    = w_push;
  assign stk_pop     = w_pop;
  assign stk_init    = w_init;
  assign stk_data_in = w_dataIn;

endmodule
